// File: rtl/mpic_prio_ctrl.sv
// rtl/mpic_prio_ctrl.sv - interrupt priority/nesting controller with Wishbone register slave
module mpic_prio_ctrl #(
  parameter int NIRQ  = 5,
  parameter int VEC_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  input  logic [1:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_ack_o,
  input  logic [NIRQ-1:0]  irq_i,
  output logic             irq_o,
  output logic [VEC_W-1:0] irq_vec_o,
  input  logic             irq_ack_i
);

  localparam logic [1:0] ADR_PEND  = 2'd0;
  localparam logic [1:0] ADR_MASK  = 2'd1;
  localparam logic [1:0] ADR_INSVC = 2'd2;
  localparam logic [1:0] ADR_VEC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACKD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NIRQ-1:0]  pend_q, pend_d;
  logic [NIRQ-1:0]  mask_q, mask_d;
  logic [NIRQ-1:0]  insvc_q, insvc_d;
  logic             irq_q, irq_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             ack_q, ack_d;

  logic [NIRQ-1:0]  blocked;
  logic [NIRQ-1:0]  eligible;
  logic [NIRQ-1:0]  eoi_bit;
  logic [NIRQ-1:0]  vec_oh;
  logic             valid;
  logic [VEC_W-1:0] cand;
  logic             vec_eligible;
  logic             accept;
  logic             wr;
  logic             run;

  // Byte selects and data bits above the source count carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_dat_i[15:NIRQ]};

  assign wr = wb_cyc_i & wb_stb_i & wb_we_i & ~ack_q;

  // Priority resolution: a source is blocked by any in-service source of equal or higher priority.
  always_comb begin
    blocked = '0;
    eoi_bit = '0;
    vec_oh  = '0;
    run     = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      if (insvc_q[i] && !run) eoi_bit[i] = 1'b1;
      run        = run | insvc_q[i];
      blocked[i] = run;
      if (vec_q == VEC_W'(i)) vec_oh[i] = 1'b1;
    end
    eligible = pend_q & mask_q & ~blocked;
    valid    = |eligible;
    cand     = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) cand = VEC_W'(i);
    end
    vec_eligible = |(eligible & vec_oh);
  end

  // Presentation FSM: latch a candidate, hold it frozen until ack or withdrawal, then settle.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_REQ;
          vec_d   = cand;
          irq_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          state_d = ST_ACKD;
          irq_d   = 1'b0;
          accept  = 1'b1;
        end else if (!vec_eligible) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_ACKD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // Register updates: live request lines always win over W1C and ack clears.
  always_comb begin
    ack_d   = wb_cyc_i & wb_stb_i & ~ack_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    insvc_d = insvc_q;
    if (wr && wb_adr_i == ADR_MASK) mask_d = wb_dat_i[NIRQ-1:0];
    if (wr && wb_adr_i == ADR_PEND) pend_d = pend_d & ~wb_dat_i[NIRQ-1:0];
    if (wr && wb_adr_i == ADR_VEC) insvc_d = insvc_d & ~eoi_bit;
    if (accept) begin
      pend_d  = pend_d & ~vec_oh;
      insvc_d = insvc_d | vec_oh;
    end
    pend_d = pend_d | irq_i;
  end

  // Read mux, combinational from the address.
  always_comb begin
    wb_dat_o = '0;
    case (wb_adr_i)
      ADR_PEND:  wb_dat_o = {{(16 - NIRQ){1'b0}}, pend_q};
      ADR_MASK:  wb_dat_o = {{(16 - NIRQ){1'b0}}, mask_q};
      ADR_INSVC: wb_dat_o = {{(16 - NIRQ){1'b0}}, insvc_q};
      ADR_VEC:   wb_dat_o = {valid, {(15 - VEC_W){1'b0}}, cand};
      default:   wb_dat_o = '0;
    endcase
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      mask_q  <= '0;
      insvc_q <= '0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insvc_q <= insvc_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
      ack_q   <= ack_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_vec_o = vec_q;
  assign wb_ack_o  = ack_q;

endmodule
